// File: rtl/timer_arbiter_pkg.sv
// rtl/timer_arbiter_pkg.sv - shared constants and state encoding for the timer arbiter
package timer_arb_pkg;

    localparam int WIDTH_DEFAULT = 5;
    localparam int NUM_REQ       = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/timer_arbiter_if.sv
// rtl/timer_arbiter_if.sv - request/grant bundle between requesters and the timer arbiter
interface timer_arbiter_if
    import timer_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic [NUM_REQ-1:0] req;
    logic [WIDTH-1:0]   len0;
    logic [WIDTH-1:0]   len1;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] done;
    logic               busy;
    logic [WIDTH-1:0]   count;

    modport master (
        output req, len0, len1,
        input  grant, done, busy, count
    );

    modport slave (
        input  req, len0, len1,
        output grant, done, busy, count
    );

endinterface

// File: rtl/timer_arbiter_count_core.sv
// rtl/timer_arbiter_count_core.sv - shared saturating down-counter with load
module count_core
    import timer_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over decrement; decrement stops at zero so the counter never wraps.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin owner selection and interval FSM for one shared down-counter
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    timer_arbiter_if.slave  bus
);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic               last_q, last_d;

    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic               en;
    logic               zero;
    logic [WIDTH-1:0]   count;
    logic               win;
    logic               owner_req;

    // last_q names the most recent winner; on a tie the other requester goes next.
    always_comb begin
        if (bus.req == 2'b11) begin
            win = ~last_q;
        end else begin
            win = bus.req[1];
        end
    end

    assign owner_req = |(bus.req & grant_q);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        last_d   = last_q;
        load     = 1'b0;
        load_val = '0;
        en       = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (bus.req != '0) begin
                    state_d  = RUN;
                    grant_d  = win ? 2'b10 : 2'b01;
                    last_d   = win;
                    load     = 1'b1;
                    load_val = win ? bus.len1 : bus.len0;
                end
            end
            RUN: begin
                // A dropped owner request is an abort and outranks interval completion.
                if (!owner_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                    load    = 1'b1;
                end else if (zero) begin
                    state_d = DONE;
                    done_d  = grant_q;
                    grant_d = '0;
                end else begin
                    en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    count_core #(.WIDTH(WIDTH)) u_count_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .count    (count),
        .zero     (zero)
    );

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.count = count;

endmodule
